// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Index/counter width that never collapses to zero bits.
  function automatic int min1_clog2(input int x);
    return (x > 2) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after prev, wrapping modulo C_NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  parameter int SRC_W     = min1_clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]     prev,
  output logic                 any,
  output logic [SRC_W-1:0]     idx
);

  localparam int unsigned NUM = C_NUM_REQ;

  logic [2*C_NUM_REQ-1:0] dbl_req;
  logic [2*C_NUM_REQ-1:0] shifted;
  logic [SRC_W:0]         start;
  logic                   found;
  int unsigned            pos;

  // Rotating the doubled vector puts prev+1 at bit 0, so the lowest set bit wins.
  always_comb begin
    start   = {1'b0, prev} + 1'b1;
    dbl_req = {req, req};
    shifted = dbl_req >> start;
    any     = |req;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (!found && shifted[k]) begin
        found = 1'b1;
        pos   = 32'(start) + k;
        if (pos >= NUM) pos = pos - NUM;
        idx   = pos[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin share of one FIFO write port; grant lasts one packet or C_MAX_BURST beats.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_NUM_REQ    = 4,
  parameter int C_MAX_BURST  = 8,
  localparam int SRC_W       = min1_clog2(C_NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_NUM_REQ-1:0]              s_valid,
  output logic [C_NUM_REQ-1:0]              s_ready,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] s_data,
  input  logic [C_NUM_REQ-1:0]              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [C_DATA_WIDTH+SRC_W:0]       m_data
);

  localparam int          BEAT_W = min1_clog2(C_MAX_BURST);
  localparam int unsigned NUM    = C_NUM_REQ;

  logic                    state;
  logic [SRC_W-1:0]        gnt;
  logic [SRC_W-1:0]        prev;
  logic [BEAT_W-1:0]       beats;

  logic                    pick_any;
  logic [SRC_W-1:0]        pick_idx;
  logic [C_DATA_WIDTH-1:0] data_arr [C_NUM_REQ];
  logic                    cap;
  logic                    m_last;
  logic                    xfer;

  rr_pick #(
    .C_NUM_REQ (C_NUM_REQ),
    .SRC_W     (SRC_W)
  ) u_pick (
    .req  (s_valid),
    .prev (prev),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM; i++)
      data_arr[i] = s_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Burst cap forces last so the remainder re-arbitrates as a fresh grant.
  always_comb begin
    cap     = (beats == BEAT_W'(C_MAX_BURST - 1));
    m_last  = s_last[gnt] | cap;
    m_valid = (state == ST_GRANT) && s_valid[gnt];
    m_data  = {m_last, gnt, data_arr[gnt]};
    s_ready = '0;
    if (state == ST_GRANT) s_ready[gnt] = m_ready;
    xfer    = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      gnt   <= '0;
      prev  <= SRC_W'(C_NUM_REQ - 1);
      beats <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt   <= pick_idx;
            prev  <= pick_idx;
            beats <= '0;
            state <= ST_GRANT;
          end
        end
        default: begin
          if (xfer) begin
            beats <= beats + 1'b1;
            if (m_last) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed packets, monitor pops expected beats.
module tb_fifo_write_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int SW = 2;
  localparam int MW = DW + SW + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     s_valid;
  logic [NR-1:0]     s_ready;
  logic [NR*DW-1:0]  s_data;
  logic [NR-1:0]     s_last;
  logic              m_valid;
  logic              m_ready;
  logic [MW-1:0]     m_data;

  logic [MW-1:0]     exp_q[$];
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .C_DATA_WIDTH (DW),
    .C_NUM_REQ    (NR),
    .C_MAX_BURST  (MB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  function automatic logic [MW-1:0] mk(input logic last, input int src, input logic [DW-1:0] d);
    return {last, SW'(src), d};
  endfunction

  task automatic monitor();
    logic          idle_chk = 1'b0;
    logic          rst_d = 1'b0;
    logic [MW-1:0] e;
    logic [NR-1:0] want_rdy;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rst_d) begin
          vectors++;
          if (m_valid !== 1'b0 || s_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: m_valid=%b s_ready=%b, required 0 and 0000", m_valid, s_ready);
          end
        end
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          vectors++;
          if (m_valid !== 1'b0 || s_ready !== '0) begin
            miscompares++;
            $display("FAIL idle_after_last: m_valid=%b s_ready=%b, required 0 and 0000", m_valid, s_ready);
          end
        end
        idle_chk = 1'b0;
        if (m_valid === 1'b1 && m_ready === 1'b0) begin
          vectors++;
          if (s_ready !== '0) begin
            miscompares++;
            $display("FAIL stall_ready: s_ready=%b, required 0000", s_ready);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: m_data=%h, required no transfer", m_data);
          end else begin
            e = exp_q.pop_front();
            want_rdy = NR'(1) << e[DW +: SW];
            if (m_data !== e || s_ready !== want_rdy) begin
              miscompares++;
              $display("FAIL beat: m_data=%h s_ready=%b, required m_data=%h s_ready=%b",
                       m_data, s_ready, e, want_rdy);
            end
          end
          idle_chk = m_data[MW-1];
        end
      end
      rst_d = reset;
    end
  endtask

  task automatic do_reset();
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input int i, input int n, input logic [DW-1:0] base);
    int t;
    for (int b = 0; b < n; b++) begin
      s_data[i*DW +: DW] = base + DW'(b);
      s_last[i]  = (b == n - 1);
      s_valid[i] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_ready[i] && t < 500);
      if (!s_ready[i]) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: req %0d beat %0d s_ready=0, required 1 within 500 cycles", i, b);
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_valid[i] = 1'b0;
    s_last[i]  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected beats outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    int         t;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    fork
      monitor();
    join_none

    // Single beat from requester 2; accepted two cycles after valid rises.
    do_reset();
    exp_q.push_back(mk(1'b1, 2, 64'hA5));
    s_data[2*DW +: DW] = 64'hA5;
    s_last[2]  = 1'b1;
    s_valid[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_idle: m_valid=%b, required 0", m_valid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || s_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL latency_grant: m_valid=%b s_ready=%b, required 1 and 0100", m_valid, s_ready);
    end
    @(posedge clk);
    #1;
    s_valid[2] = 1'b0;
    s_last[2]  = 1'b0;
    drain();

    // All four requesters, one-beat packets: order 0,1,2,3,0.
    do_reset();
    exp_q.push_back(mk(1'b1, 0, 64'h100));
    exp_q.push_back(mk(1'b1, 1, 64'h101));
    exp_q.push_back(mk(1'b1, 2, 64'h102));
    exp_q.push_back(mk(1'b1, 3, 64'h103));
    exp_q.push_back(mk(1'b1, 0, 64'h200));
    fork
      begin
        send(0, 1, 64'h100);
        send(0, 1, 64'h200);
      end
      send(1, 1, 64'h101);
      send(2, 1, 64'h102);
      send(3, 1, 64'h103);
    join
    drain();

    // Burst cap: req1 12 beats split 8 + 4, req3 slots in between.
    do_reset();
    for (int b = 0; b < 8; b++) exp_q.push_back(mk(b == 7, 1, 64'h1000 + 64'(b)));
    exp_q.push_back(mk(1'b0, 3, 64'h3000));
    exp_q.push_back(mk(1'b1, 3, 64'h3001));
    for (int b = 8; b < 12; b++) exp_q.push_back(mk(b == 11, 1, 64'h1000 + 64'(b)));
    fork
      send(1, 12, 64'h1000);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(3, 2, 64'h3000);
      end
    join
    drain();

    // Backpressure: m_ready cycles 1,0,0,1 across a 3-beat packet.
    do_reset();
    pat = 4'b1001;
    exp_q.push_back(mk(1'b0, 0, 64'h800));
    exp_q.push_back(mk(1'b0, 0, 64'h801));
    exp_q.push_back(mk(1'b1, 0, 64'h802));
    fork
      send(0, 3, 64'h800);
      begin
        for (int k = 0; k < 16; k++) begin
          m_ready = pat[k % 4];
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    drain();

    // Reset after beat 2 of 5, then req0 must beat req3.
    do_reset();
    exp_q.push_back(mk(1'b0, 2, 64'h500));
    exp_q.push_back(mk(1'b0, 2, 64'h501));
    for (int b = 0; b < 2; b++) begin
      s_data[2*DW +: DW] = 64'h500 + 64'(b);
      s_last[2]  = 1'b0;
      s_valid[2] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_ready[2] && t < 500);
      if (!s_ready[2]) begin
        vectors++;
        miscompares++;
        $display("FAIL midgrant_timeout: s_ready[2]=0, required 1 within 500 cycles");
      end
      @(posedge clk);
      #1;
    end
    s_data[2*DW +: DW] = 64'h502;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s_valid[2] = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: m_valid=%b s_ready=%b, required 0 and 0000", m_valid, s_ready);
    end
    exp_q.push_back(mk(1'b1, 0, 64'h600));
    exp_q.push_back(mk(1'b1, 3, 64'h700));
    fork
      send(0, 1, 64'h600);
      send(3, 1, 64'h700);
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of one valid/ready FIFO (same handshake as `myfifo` write side) among `C_NUM_REQ` producers. A grant is held for one packet or at most `C_MAX_BURST` beats, whichever ends first. Each beat is tagged with its source index so that the consumer on the FIFO read side can demultiplex the data. The block sits directly in front of the FIFO's `write_valid`/`write_ready`/`write_data` inputs.

## Interface
- `C_DATA_WIDTH`, default 64: payload width per requester and at the output.
- `C_NUM_REQ`, default 4: number of requesters. Must be ≥ 2.
- `C_MAX_BURST`, default 8: maximum beats per grant. Must be ≥ 1.
- `SRC_W` (localparam): max(1, $clog2(C_NUM_REQ)).
- Clocking and reset (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_valid`  in  C_NUM_REQ  per-requester beat valid.
- `s_ready`  out  C_NUM_REQ  per-requester beat accept.
- `s_data`  in  C_NUM_REQ*C_DATA_WIDTH  requester i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- `s_last`  in  C_NUM_REQ  marks the final beat of a packet.
- `m_valid`  out  1  to FIFO `write_valid`.
- `m_ready`  in  1  from FIFO `write_ready`.
- `m_data`  out  C_DATA_WIDTH+SRC_W+1  {`last`, `src`, `payload`} packed MSB→LSB. Connect to FIFO `write_data` with FIFO width = C_DATA_WIDTH+SRC_W+1.

## Operation
- **States:** IDLE and GRANT. Registers: `state`, `gnt` (SRC_W bits), `prev` (SRC_W bits), `beats` (max(1,$clog2(C_MAX_BURST)) bits).
- **Reset:** `state` = IDLE, `gnt` = 0, `prev` = C_NUM_REQ-1 (requester 0 wins first), `beats` = 0. Outputs are combinational from state and are therefore `m_valid` = 0 and `s_ready` = 0 during and right after reset.
- **IDLE:**
  - If any `s_valid` is high, select the first asserted index scanning `prev+1, prev+2, …` modulo C_NUM_REQ.
  - Load `gnt` and `prev` with that index, clear `beats`, and go to GRANT.
  - No beat transfers in IDLE: `m_valid` = 0 and all `s_ready` = 0.
- **GRANT:**
  - `m_valid` = `s_valid[gnt]`.
  - `m_data` = {`s_last[gnt]` OR (`beats` == C_MAX_BURST-1), `gnt`, `s_data[gnt]`}.
  - `s_ready[gnt]` = `m_ready`. All other `s_ready` bits are 0.
- **Handshake:** a transfer occurs when `m_valid` && `m_ready`.
  - On a transfer, `beats` increments.
  - If the transferred beat carried `last`=1 (packet end or burst cap), go to IDLE.
- **Grant hold:** a grant is never revoked while `s_valid[gnt]` is low. The requester keeps the port until its `last` or the burst cap.
- **Burst cap:** a cap cut splits the packet. The remainder competes again in round-robin, and its first beat starts a new grant.
- Non-granted requesters see `s_ready` = 0 and must hold their data (AXI-style valid stability).
- **Reset mid-grant:** return to IDLE the next cycle. A partially sent packet is abandoned with no `last`; the downstream FIFO is expected to be reset together with this block.

## Timing
- Arbitration costs one IDLE cycle per grant. Steady-state peak throughput is therefore C_MAX_BURST/(C_MAX_BURST+1) beats per cycle with multiple requesters active.
- Latency from `s_valid` rise (port idle) to the first accepted beat is 2 cycles, given `m_ready`=1.
- The `s_ready` ← `m_ready` and `m_valid`/`m_data` ← `s_*[gnt]` paths are combinational. There is no register stage; the FIFO output provides the timing break.
- `m_ready` low stalls in place. `beats` and `state` are unchanged and `m_data` tracks the granted inputs.
- With a single active requester, the grant returns to it after the IDLE cycle. Requesters are never starved: each waits at most C_NUM_REQ-1 grants.

## Structure
- Package `fifo_arb_pkg`: state encoding (IDLE=0, GRANT=1) and the `SRC_W`/beat-width helper functions (max(1,$clog2(x))).
- Sub-module `rr_pick`: purely combinational. Inputs are `req[C_NUM_REQ]` and `prev`; outputs are `any` and `idx`. Implement as a doubled request vector rotated by prev+1 plus a priority encoder.
- The top level holds the FSM, counters and output muxes only.

## Test plan
- **Reset then single beat:** assert `reset` for 2 cycles → `m_valid`=0 and `s_ready`=0 throughout. Then `s_valid[2]`=1, `s_last[2]`=1, data 0xA5, `m_ready`=1 → one transfer 2 cycles later with `m_data` = {1, 2, 0xA5}, then IDLE.
- **All four requesters, 1-beat packets, `m_ready`=1:** grant order 0,1,2,3,0. Each transfer is followed by an IDLE cycle.
- **Burst cap (C_MAX_BURST=8):** requester 1 sends 12 beats with `last` on beat 12 while requester 3 waits. Required order: beats 1–8 of req1, with `last`=1 forced on beat 8; then req3's packet; then req1 beats 9–12 with `last` on beat 12.
- **Backpressure:** `m_ready` toggles 1,0,0,1 during a 3-beat packet → exactly 3 transfers, each `s_ready[gnt]` pulse coincides with `m_ready`=1, and `beats` is held during stalls.
- **Reset mid-grant:** assert `reset` after beat 2 of a 5-beat packet → next cycle IDLE with `prev`=C_NUM_REQ-1. Afterwards requester 0 wins over a simultaneous requester 3.
